tdc_packetizer: RTL and testbench
=================================

TDC_PACKETIZER -- requirements
Module: tdc_packetizer

Interface
REQ-001 Parameter DATA_BYTES, default 3, number of payload bytes per measurement word.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two, number of buffered input words.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  measurement word present on in_data.
REQ-007 in_ready  output  1  packetizer can accept a word.
REQ-008 in_data  input  8*DATA_BYTES  measurement word.
REQ-009 out_valid  output  1  byte present on out_data for the UART serializer.
REQ-010 out_ready  input  1  serializer accepts the byte.
REQ-011 out_data  output  8  frame byte.
REQ-012 busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-013 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL be 1 exactly when the FIFO holds fewer than FIFO_DEPTH words; a pop in the same cycle SHALL NOT raise in_ready.
REQ-015 Each word SHALL produce one frame of 3+DATA_BYTES bytes, in this order: SYNC_BYTE, SEQ, payload bytes MSB first, CHK.
REQ-016 SEQ SHALL be an 8-bit frame counter: 0 after reset, +1 per completed frame, wrapping 0xFF->0x00.
REQ-017 CHK SHALL be the XOR of SEQ and all payload bytes; SYNC_BYTE SHALL NOT be included.
REQ-018 State machine states SHALL be IDLE, SYNC, SEQ, DATA, CHK.
REQ-019 IDLE with FIFO non-empty SHALL pop one word into a frame register and go to SYNC on the next cycle; out_valid SHALL be 0 in IDLE.
REQ-020 SYNC->SEQ, SEQ->DATA and DATA->CHK transitions SHALL occur only on an output transfer.
REQ-021 DATA SHALL be left after DATA_BYTES transfers, tracked by a byte counter.
REQ-022 An output transfer in CHK SHALL increment SEQ and return to IDLE.
REQ-023 out_valid SHALL be 1 in SYNC, SEQ, DATA and CHK.
REQ-024 out_data SHALL be driven from registers and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Latency: a word accepted at cycle t into an empty, idle block SHALL give out_valid=1 with SYNC_BYTE at cycle t+2.
REQ-026 Back-to-back frames SHALL have exactly one IDLE cycle between the CHK transfer and the next SYNC_BYTE.
REQ-027 The FIFO SHALL accept a push and a pop in the same cycle with the count unchanged; a push SHALL be ignored when full and a pop SHALL NOT occur when empty.
REQ-028 The FIFO SHALL preserve word order; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 busy SHALL be 1 when the state is not IDLE or the FIFO count is non-zero.
REQ-030 The captured frame word SHALL be unaffected by later input transfers.

Reset
REQ-031 While rst=1: state=IDLE, FIFO empty, SEQ=0, byte counter=0, out_valid=0, out_data=0, in_ready=0, busy=0.
REQ-032 in_ready SHALL return to 1 on the first cycle after rst deasserts.
REQ-033 Reset asserted mid-frame SHALL abandon the frame and discard all buffered words; no partial frame SHALL resume afterwards.

Verification
REQ-034 Single word: push in_data=0x123456 after reset, out_ready=1 -> bytes A5,00,12,34,56,70; SYNC_BYTE appears 2 cycles after the push; busy=0 afterwards.
REQ-035 Backpressure: out_ready=0 for 5 cycles while SEQ=0x00 is presented -> out_valid=1 and out_data=0x00 hold stable; the frame completes correctly after release.
REQ-036 Fill: out_ready=0, 6 words offered back-to-back -> exactly 5 accepted (1 in frame, 4 in FIFO) and in_ready=0 while the 6th is offered; releasing out_ready emits 5 frames in order with SEQ 0..4.
REQ-037 SEQ wrap: 257 frames with payload 0x000000 -> frame 256 has SEQ=0xFF and CHK=0xFF; frame 257 has SEQ=0x00 and CHK=0x00.
REQ-038 Reset mid-frame: rst pulsed for 1 cycle during DATA with 2 words queued -> out_valid=0 next cycle, busy=0, and the next pushed word 0xABCDEF emits A5,00,AB,CD,EF,89.

Source files
------------

// File: rtl/tdc_packetizer.sv
// TDC measurement packetizer: buffers measurement words in a small FIFO and
// serializes each one as a SYNC/SEQ/payload/CHK byte frame toward a UART.
module tdc_packetizer #(
  parameter int         DATA_BYTES = 3,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic                    busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_DATA,
    ST_CHK
  } state_t;

  state_t state_q, state_d;

  logic [8*DATA_BYTES-1:0] mem_q [FIFO_DEPTH];
  logic [8*DATA_BYTES-1:0] frame_q;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW:0]             count_q, count_d;
  logic [7:0]              seq_q, seq_d;
  logic [7:0]              out_data_q, out_data_d;
  logic [CW-1:0]           byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]           next_idx;
  logic [7:0]              chk_byte;
  logic [7:0]              pay_bytes [DATA_BYTES];

  logic push;
  logic pop;
  logic xfer;
  logic fifo_empty;
  logic last_byte;

  // Payload bytes in transmission order: index 0 is the most significant byte.
  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_pay
      assign pay_bytes[gi] = frame_q[8*(DATA_BYTES-1-gi) +: 8];
    end
  endgenerate

  always_comb begin
    chk_byte = seq_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      chk_byte = chk_byte ^ pay_bytes[i];
    end
  end

  assign fifo_empty = (count_q == '0);
  assign in_ready   = !rst && (count_q < FULL_CNT);
  assign push       = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign last_byte  = (byte_cnt_q == LAST_IDX);
  assign next_idx   = byte_cnt_q + CW'(1);
  assign busy       = !rst && ((state_q != ST_IDLE) || !fifo_empty);
  assign out_data   = out_data_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty)       state_d = ST_SYNC;
      ST_SYNC: if (xfer)              state_d = ST_SEQ;
      ST_SEQ:  if (xfer)              state_d = ST_DATA;
      ST_DATA: if (xfer && last_byte) state_d = ST_CHK;
      ST_CHK:  if (xfer)              state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = 1'b0;
    pop       = 1'b0;
    if (!rst) begin
      out_valid = (state_q != ST_IDLE);
      pop       = (state_q == ST_IDLE) && !fifo_empty;
    end
  end

  // Datapath next-state: FIFO bookkeeping and the pre-loaded output byte.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    byte_cnt_d = byte_cnt_q;
    out_data_d = out_data_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    if (pop) out_data_d = SYNC_BYTE;

    // The next byte is loaded on the transfer that retires the current one,
    // so out_data only ever changes on an accepted byte.
    if (xfer) begin
      case (state_q)
        ST_SYNC: out_data_d = seq_q;
        ST_SEQ: begin
          out_data_d = pay_bytes[0];
          byte_cnt_d = '0;
        end
        ST_DATA: begin
          if (last_byte) begin
            out_data_d = chk_byte;
            byte_cnt_d = '0;
          end else begin
            out_data_d = pay_bytes[next_idx];
            byte_cnt_d = next_idx;
          end
        end
        ST_CHK: begin
          seq_d      = seq_q + 8'd1;
          out_data_d = '0;
        end
        default: out_data_d = out_data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      byte_cnt_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      byte_cnt_q <= byte_cnt_d;
      out_data_q <= out_data_d;
    end
  end

  // Word storage with a registered read straight into the frame register.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
    if (pop)  frame_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_tdc_packetizer.sv
// Bench for tdc_packetizer: directed and random traffic checked against a
// byte-stream model built from each accepted word and a running frame counter.
module tb_tdc_packetizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  tdc_packetizer #(
    .DATA_BYTES(3),
    .FIFO_DEPTH(4),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         accepted = 0;
  logic [7:0] model_seq;
  logic [7:0] exp_q[$];
  logic [7:0] obs_log[$];
  logic       s_out_valid, s_busy, s_in_ready;
  logic [7:0] s_out_data;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: every accepted word becomes sync, seq, three payload bytes, xor.
  task automatic model_push(input logic [23:0] w);
    exp_q.push_back(8'hA5);
    exp_q.push_back(model_seq);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(model_seq ^ w[23:16] ^ w[15:8] ^ w[7:0]);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    obs_log.delete();
    model_seq = 8'd0;
    accepted  = 0;
  endtask

  task automatic step(input logic v, input logic [23:0] d, input logic ordy);
    logic [7:0] e;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy;
    s_in_ready  = in_ready;
    if (out_valid && ordy) begin
      obs_log.push_back(out_data);
      chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("out byte %02h expected %02h", out_data, e);
        chk("out_byte", 32'(out_data), 32'(e));
      end
    end
    if (v && in_ready) begin
      accepted++;
      $display("in word %06h accepted", d);
      model_push(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound, output int steps);
    steps = 0;
    while (exp_q.size() != 0 && steps < bound) begin
      step(1'b0, 24'h0, 1'b1);
      steps++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
    step(1'b0, 24'h0, 1'b1);
    chk("idle_busy", 32'(s_busy), 32'd0);
    chk("idle_out_valid", 32'(s_out_valid), 32'd0);
  endtask

  task automatic check_log6(input string tag, input logic [47:0] bytes);
    logic [47:0] b;
    b = bytes;
    chk({tag, "_len"}, 32'(obs_log.size()), 32'd6);
    if (obs_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk(tag, 32'(obs_log[i]), 32'(b[8*(5-i) +: 8]));
      end
    end
  endtask

  initial begin
    int          steps;
    int          guard;
    logic [23:0] w;

    model_reset();
    reset_dut();

    // Single word: latency and exact frame contents.
    step(1'b1, 24'h123456, 1'b1);
    step(1'b0, 24'h0, 1'b1);
    chk("lat_t1_valid", 32'(s_out_valid), 32'd0);
    step(1'b0, 24'h0, 1'b1);
    chk("lat_t2_valid", 32'(s_out_valid), 32'd1);
    chk("lat_t2_sync", 32'(s_out_data), 32'hA5);
    drain(50, steps);
    check_log6("single_frame", 48'hA5_00_12_34_56_70);

    // Backpressure while SEQ=0 is presented.
    reset_dut();
    w = 24'($urandom);
    step(1'b1, w, 1'b1);
    step(1'b0, 24'h0, 1'b1);
    step(1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 24'h0, 1'b0);
      chk("stall_valid", 32'(s_out_valid), 32'd1);
      chk("stall_data", 32'(s_out_data), 32'h00);
    end
    drain(50, steps);
    chk("stall_frame_len", 32'(obs_log.size()), 32'd6);

    // Fill: six offered with the output stalled, five accepted.
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom);
      step(1'b1, w, 1'b0);
      if (i == 5) chk("full_in_ready", 32'(s_in_ready), 32'd0);
    end
    chk("fill_accepted", 32'(accepted), 32'd5);
    drain(200, steps);
    chk("b2b_cycles", 32'(steps), 32'd34);
    chk("fill_bytes", 32'(obs_log.size()), 32'd30);

    // Random traffic with random stalls.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      w = 24'($urandom);
      step(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 3) != 0));
    end
    drain(400, steps);

    // SEQ wrap over 257 all-zero frames.
    reset_dut();
    guard = 0;
    while (accepted < 257 && guard < 6000) begin
      step(1'b1, 24'h0, 1'($urandom_range(0, 3) != 0));
      guard++;
    end
    chk("wrap_accepted", 32'(accepted), 32'd257);
    drain(400, steps);
    chk("wrap_bytes", 32'(obs_log.size()), 32'd1542);
    if (obs_log.size() >= 1542) begin
      chk("wrap_f256_seq", 32'(obs_log[255*6+1]), 32'hFF);
      chk("wrap_f256_chk", 32'(obs_log[255*6+5]), 32'hFF);
      chk("wrap_f257_seq", 32'(obs_log[256*6+1]), 32'h00);
      chk("wrap_f257_chk", 32'(obs_log[256*6+5]), 32'h00);
    end

    // Reset mid-frame with two words queued.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      w = 24'($urandom);
      step(1'b1, w, 1'b0);
    end
    chk("mid_accepted", 32'(accepted), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 1'b1);
    chk("mid_in_frame", 32'(s_out_valid), 32'd1);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 24'h0, 1'b1);
    chk("mid_after_valid", 32'(s_out_valid), 32'd0);
    chk("mid_after_busy", 32'(s_busy), 32'd0);
    chk("mid_after_ready", 32'(s_in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 24'h0, 1'b1);
      chk("mid_no_resume", 32'(s_out_valid), 32'd0);
    end
    step(1'b1, 24'hABCDEF, 1'b1);
    drain(50, steps);
    check_log6("post_rst_frame", 48'hA5_00_AB_CD_EF_89);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
